// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressable RV32 data memory with valid/ready request, wait states and error reporting
// Ports: clk/rst (async, active-high); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata request side;
//        rsp_valid/rsp_rdata/rsp_err one-cycle response; busy while the access is in progress.
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);
  localparam int BYTES = DEPTH_WORDS * 4;
  localparam int AW = $clog2(BYTES);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic          w_accept;
  logic          w_access;
  logic          w_err;
  logic [AW-3:0] w_idx;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  assign req_ready = r_state != S_WAIT;
  assign busy      = r_state == S_WAIT;
  assign rsp_valid = r_state == S_RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_accept = req_valid && req_ready;
  assign w_access = r_state == S_WAIT && r_cnt == 4'd0;
  // Stores only allow B/H/W; loads additionally allow BU/HU.
  assign w_err = (r_addr >= 32'(BYTES))
              || (r_f3[1:0] == 2'b01 && r_addr[0])
              || (r_f3[1:0] == 2'b10 && r_addr[1:0] != 2'b00)
              || (r_we ? (r_f3[2] || r_f3[1:0] == 2'b11) : (r_f3[1:0] == 2'b11 || r_f3 == 3'b110));
  assign w_idx  = r_addr[AW-1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = r_addr[1] ? (r_addr[0] ? w_word[31:24] : w_word[23:16])
                            : (r_addr[0] ? w_word[15:8]  : w_word[7:0]);
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
  // funct3[2] selects zero extension for BU/HU.
  assign w_load = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_byte[7]}}, w_byte}
                : r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_half[15]}}, w_half}
                : w_word;
  assign w_be = r_f3[1:0] == 2'b00 ? 4'b0001 << r_addr[1:0]
              : r_f3[1:0] == 2'b01 ? 4'b0011 << {r_addr[1], 1'b0}
              : 4'b1111;
  assign w_wd = r_f3[1:0] == 2'b00 ? {4{r_wdata[7:0]}}
              : r_f3[1:0] == 2'b01 ? {2{r_wdata[15:0]}}
              : r_wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_WAIT;
      r_cnt   <= 4'(WAIT_STATES);
      r_we    <= req_we;
      r_f3    <= req_funct3;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end else if (r_state == S_WAIT) begin
      if (r_cnt == 4'd0) begin
        r_state <= S_RESP;
        r_rdata <= (w_err || r_we) ? '0 : w_load;
        r_err   <= w_err;
      end else begin
        r_cnt <= r_cnt - 4'd1;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end
  // Contents are not reset; a reset clears the FSM first, so a pending store never commits.
  always_ff @(posedge clk) begin
    if (w_access && r_we && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
  end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised, byte-addressable RV32 data memory with a request/response handshake and configurable wait states. It serves loads and stores for all RV32I widths (LB/LH/LW/LBU/LHU/SB/SH/SW):

- byte-lane stores;
- sign/zero-extended loads;
- misalignment and out-of-range error reporting.

It sits between the core's MEM stage and the data store. It replaces the fixed word-only, combinational-read data memory, and the core stalls on `req_ready`/`rsp_valid`.

## Interface
Reset is asynchronous and active-high; the clock is `clk` and the reset is `rst`.

Parameters:
- `DEPTH_WORDS`, default 64: number of 32-bit words. Must be a power of two, ≥4.
- `WAIT_STATES`, default 1: extra access cycles, 0..15.
- Localparam `BYTES = DEPTH_WORDS*4`.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request can be accepted this cycle.
- `req_we` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, LSB-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` output 1: response valid, one-cycle pulse.
- `rsp_rdata` output 32: extended load data; 0 for stores and errors.
- `rsp_err` output 1: misaligned, out-of-range or illegal funct3.
- `busy` output 1: high in the WAIT state.

## Operation
States:
- **IDLE**: `req_ready`=1.
- **WAIT**: `req_ready`=0, `busy`=1.
- **RESP**: `rsp_valid`=1, `req_ready`=1.

Transitions:
- Acceptance happens when `req_valid` and `req_ready` are both high at a rising edge. On acceptance, latch `we`, `funct3`, `addr` and `wdata`, load `cnt` ← `WAIT_STATES` (4-bit), and go to WAIT.
- **WAIT**: if `cnt`==0, perform the access and go to RESP; otherwise `cnt` ← `cnt`−1.
- **RESP**: if a new request is accepted, go to WAIT; otherwise go to IDLE.

Error detection (evaluated on the latched request):
- Misaligned: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
- Out of range: `addr` ≥ `BYTES`.
- Illegal funct3: 011, 110 or 111 for loads; anything other than 000/001/010 for stores.
- Any error means no memory write, `rsp_rdata`=0 and `rsp_err`=1.

Memory access:
- The word index is `addr[$clog2(BYTES)-1:2]`.
- **Store**: only the addressed lanes are written.
  - SB writes lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {`addr[1]`*2, +1} with `wdata[15:0]`.
  - SW writes all 4 lanes.
  - Other bytes of the word are unchanged.
- **Load**: select the byte or half by the address low bits. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word.
- The access (write commit and `rsp_rdata`/`rsp_err` register update) happens at the WAIT→RESP edge.
- Memory contents are not reset.

## Timing
- Reset: state=IDLE, `cnt`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `busy`=0, `req_ready`=1 (combinational from state).
- Reset mid-operation: the pending request is dropped. A store that has not yet reached its WAIT→RESP edge never writes.
- Latency: with acceptance at edge E, `rsp_valid` is high for exactly the one cycle after edge E+`WAIT_STATES`+1.
- Throughput: one request per `WAIT_STATES`+2 cycles when back-to-back (accept during RESP).
- `rsp_rdata`/`rsp_err` hold their values until the next access edge. They are meaningful only when `rsp_valid`=1.
- Store-then-load back-to-back: the load accepted in the store's RESP cycle sees the stored data, because the write was committed before RESP.
- There is no response back-pressure; the requester must sample in the RESP cycle.
- `WAIT_STATES`=0: WAIT lasts 1 cycle; the response arrives 1 cycle after acceptance.

## Test plan
- **Reset values**: assert `rst` asynchronously mid-cycle → all outputs at their reset values immediately, `req_ready`=1. Then SW 0x11223344 @0x10 with `rst` pulsed during WAIT, then LW @0x10 → not 0x11223344 (no write). Bench preloads 0 first.
- **Word/byte paths**: SW 0x80FF7F01 @0x20, then:
  - LB @0x23 → 0xFFFFFF80, `rsp_err`=0.
  - LBU @0x23 → 0x00000080.
  - LH @0x22 → 0xFFFF80FF.
  - LHU @0x20 → 0x00007F01.
- **Lane stores**: SW 0 @0x40, SB 0xAB @0x41, SH 0xCDEF @0x42, LW @0x40 → 0xCDEFAB00.
- **Errors**:
  - LW @0x22 → `rsp_err`=1, `rsp_rdata`=0.
  - SH @0x41 with data 0xFFFF → `rsp_err`=1; a following LW @0x40 is unchanged.
  - LW @`BYTES` → `rsp_err`=1.
  - funct3=011 → `rsp_err`=1.
- **Latency/handshake**: run with `WAIT_STATES`=0, 1 and 3. Accept at edge E → `rsp_valid` one cycle after E+W+1, and `busy` high W+1 cycles. A back-to-back SW then LW to the same address, with the LW accepted in RESP, returns the new data, and the LW's `rsp_valid` follows W+2 cycles after the SW's.
